// File: rtl/updown_counter_param.sv
// ============================================================================
// updown_counter_param
// ----------------------------------------------------------------------------
// Purpose:
//   Loadable up/down counter with configurable width, a prescaled step tick
//   and a selectable behaviour at the count boundaries (saturate, wrap or
//   auto-reload from the last loaded value). A one-cycle registered pulse on
//   tc marks every boundary event. Intended as a general timer/event counter
//   whose zero/tc outputs feed control FSMs.
//
// Parameters:
//   WIDTH     counter, load and reload width in bits (>= 2)
//   PRESCALE  step tick period in clock cycles (1 = every cycle, >= 1)
//   MODE      boundary mode: 0 = saturate, 1 = wrap, 2 = auto-reload;
//             any other value behaves as saturate
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   in       in   WIDTH  load value, sampled when latch = 1
//   latch    in   1      synchronous load of count and reload register
//   inc      in   1      request a +1 step on the next tick
//   dec      in   1      request a -1 step on the next tick
//   count    out  WIDTH  current count (registered)
//   zero     out  1      count == 0
//   max      out  1      count == all ones
//   tc       out  1      one-cycle boundary event pulse (registered)
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1,
    parameter int MODE     = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             max,
    output logic             tc
);

    typedef enum logic [1:0] {
        BOUND_SATURATE = 2'd0,
        BOUND_WRAP     = 2'd1,
        BOUND_RELOAD   = 2'd2
    } bound_mode_t;

    // Unsupported MODE values fall back to saturating behaviour.
    localparam bound_mode_t BOUND_MODE = (MODE == 1) ? BOUND_WRAP :
                                         (MODE == 2) ? BOUND_RELOAD :
                                                       BOUND_SATURATE;

    // A one-bit prescaler is kept even when PRESCALE is 1 so the tick
    // comparison below stays uniform; it simply never leaves zero then.
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0]   PRE_LAST  = PSW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] reload;
    logic [PSW-1:0]   prescaler;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload_nxt;
    logic [PSW-1:0]   prescaler_nxt;
    logic             tc_nxt;
    logic             tick;
    logic             step;

    // The step tick fires on the last prescaler phase; inc and dec together
    // cancel out and request nothing.
    assign tick = (prescaler == PRE_LAST);
    assign step = tick & (inc ^ dec);

    // Flags are decoded straight from the count register so they move in
    // the same cycle as count without an extra pipeline stage.
    assign zero = (count == '0);
    assign max  = (count == COUNT_MAX);

    // Next-state logic. A load wins over stepping and restarts the prescaler
    // so that the first step after a load always lands a full PRESCALE
    // cycles later. Running past either end raises tc and then applies the
    // selected boundary behaviour instead of the normal +/-1.
    always_comb begin
        count_nxt     = count;
        reload_nxt    = reload;
        prescaler_nxt = tick ? '0 : prescaler + PSW'(1);
        tc_nxt        = 1'b0;

        if (latch) begin
            count_nxt     = in;
            reload_nxt    = in;
            prescaler_nxt = '0;
        end else if (step) begin
            if (inc) begin
                if (count == COUNT_MAX) begin
                    tc_nxt = 1'b1;
                    case (BOUND_MODE)
                        BOUND_WRAP:   count_nxt = '0;
                        BOUND_RELOAD: count_nxt = reload;
                        default:      count_nxt = count;
                    endcase
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    tc_nxt = 1'b1;
                    case (BOUND_MODE)
                        BOUND_WRAP:   count_nxt = COUNT_MAX;
                        BOUND_RELOAD: count_nxt = reload;
                        default:      count_nxt = count;
                    endcase
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    // State registers. Reset is asynchronous and clears everything,
    // including the reload value, so a counter in auto-reload mode must be
    // loaded again after reset before it reloads anything but zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            reload    <= '0;
            prescaler <= '0;
            tc        <= 1'b0;
        end else begin
            count     <= count_nxt;
            reload    <= reload_nxt;
            prescaler <= prescaler_nxt;
            tc        <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// ============================================================================
// tb_updown_counter_param
// ----------------------------------------------------------------------------
// Five counters share one set of inputs: saturate, wrap, auto-reload,
// saturate with PRESCALE=4, and an illegal MODE=3 that should saturate.
// A behavioural model of each counter runs alongside them.
// ============================================================================
module tb_updown_counter_param;

    localparam int N = 5;
    localparam int W = 4;
    localparam int TOP = 15;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] in;
    logic         latch;
    logic         inc;
    logic         dec;
    logic [W-1:0] cnt [N];
    logic         zr  [N];
    logic         mx  [N];
    logic         tcv [N];

    int pre_of  [N] = '{1, 1, 1, 4, 1};
    int mode_of [N] = '{0, 1, 2, 0, 3};

    int mc [N];
    int mr [N];
    int mp [N];
    int mt [N];

    int checks;
    int passes;

    for (genvar g = 0; g < N; g++) begin : g_dut
        updown_counter_param #(
            .WIDTH   (W),
            .PRESCALE((g == 3) ? 4 : 1),
            .MODE    ((g == 4) ? 3 : ((g == 3) ? 0 : g))
        ) dut (
            .clock  (clock),
            .reset_n(reset_n),
            .in     (in),
            .latch  (latch),
            .inc    (inc),
            .dec    (dec),
            .count  (cnt[g]),
            .zero   (zr[g]),
            .max    (mx[g]),
            .tc     (tcv[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain arithmetic on integers, one entry per counter.
    // The prescaler is a cycle phase that restarts on a load.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                mc[i] = 0; mr[i] = 0; mp[i] = 0; mt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit ticked;
                ticked = (mp[i] == pre_of[i] - 1);
                mp[i] = (mp[i] + 1) % pre_of[i];
                mt[i] = 0;
                if (latch) begin
                    mc[i] = int'(in); mr[i] = int'(in); mp[i] = 0;
                end else if (ticked && (inc != dec)) begin
                    int target;
                    target = inc ? mc[i] + 1 : mc[i] - 1;
                    if (target < 0 || target > TOP) begin
                        mt[i] = 1;
                        if (mode_of[i] == 1) mc[i] = (target + TOP + 1) % (TOP + 1);
                        else if (mode_of[i] == 2) mc[i] = mr[i];
                    end else begin
                        mc[i] = target;
                    end
                end
            end
        end
    end

    task automatic tick_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int v, input bit l, input bit i, input bit d);
        in = W'(v); latch = l; inc = i; dec = d;
    endtask

    task automatic test_reset();
        drive(9, 1, 0, 0);
        tick_clock();
        drive(0, 0, 0, 0);
        checks++;
        if (cnt[0] !== 4'd9) $display("[TB] FAIL reset_preload: got %0d expected 9", cnt[0]);
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cnt[0] !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", cnt[0]);
        else passes++;
        checks++;
        if (zr[0] !== 1'b1) $display("[TB] FAIL reset_zero: got %0b expected 1", zr[0]);
        else passes++;
        checks++;
        if (tcv[0] !== 1'b0 || mx[0] !== 1'b0)
            $display("[TB] FAIL reset_tc_max: got tc=%0b max=%0b expected 0 0", tcv[0], mx[0]);
        else passes++;
        #1 reset_n = 1'b1;
    endtask

    task automatic test_load_dec();
        int exp_c [7] = '{4, 3, 2, 1, 0, 0, 0};
        int exp_t [7] = '{0, 0, 0, 0, 0, 1, 1};
        drive(5, 1, 0, 0);
        tick_clock();
        checks++;
        if (cnt[0] !== 4'd5) $display("[TB] FAIL load5: got %0d expected 5", cnt[0]);
        else passes++;
        drive(0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            tick_clock();
            checks++;
            if (cnt[0] !== W'(exp_c[k]) || tcv[0] !== exp_t[k][0] || zr[0] !== (exp_c[k] == 0))
                $display("[TB] FAIL sat_dec step %0d: got count=%0d tc=%0b zero=%0b expected %0d %0b %0b",
                         k, cnt[0], tcv[0], zr[0], exp_c[k], exp_t[k][0], exp_c[k] == 0);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        drive(15, 1, 0, 0);
        tick_clock();
        checks++;
        if (cnt[1] !== 4'd15 || mx[1] !== 1'b1)
            $display("[TB] FAIL wrap_load: got count=%0d max=%0b expected 15 1", cnt[1], mx[1]);
        else passes++;
        drive(0, 0, 1, 0);
        tick_clock();
        checks++;
        if (cnt[1] !== 4'd0 || tcv[1] !== 1'b1 || mx[1] !== 1'b0)
            $display("[TB] FAIL wrap_up: got count=%0d tc=%0b max=%0b expected 0 1 0", cnt[1], tcv[1], mx[1]);
        else passes++;
        drive(0, 0, 0, 0);
        tick_clock();
        checks++;
        if (cnt[1] !== 4'd0 || tcv[1] !== 1'b0)
            $display("[TB] FAIL wrap_hold: got count=%0d tc=%0b expected 0 0", cnt[1], tcv[1]);
        else passes++;
        drive(0, 0, 0, 1);
        tick_clock();
        checks++;
        if (cnt[1] !== 4'd15 || tcv[1] !== 1'b1)
            $display("[TB] FAIL wrap_down: got count=%0d tc=%0b expected 15 1", cnt[1], tcv[1]);
        else passes++;
    endtask

    task automatic test_reload();
        int exp_c [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
        int exp_t [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        drive(3, 1, 0, 0);
        tick_clock();
        drive(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            tick_clock();
            checks++;
            if (cnt[2] !== W'(exp_c[k]) || tcv[2] !== exp_t[k][0])
                $display("[TB] FAIL reload step %0d: got count=%0d tc=%0b expected %0d %0b",
                         k, cnt[2], tcv[2], exp_c[k], exp_t[k][0]);
            else passes++;
        end
    endtask

    task automatic test_prescale();
        drive(8, 1, 0, 0);
        tick_clock();
        drive(0, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            tick_clock();
            checks++;
            if (cnt[3] !== W'(8 - k / 4))
                $display("[TB] FAIL prescale edge %0d: got %0d expected %0d", k, cnt[3], 8 - k / 4);
            else passes++;
        end
    endtask

    task automatic test_priority();
        drive(6, 1, 0, 1);
        tick_clock();
        checks++;
        if (cnt[0] !== 4'd6 || cnt[3] !== 4'd6)
            $display("[TB] FAIL latch_over_dec: got %0d/%0d expected 6/6", cnt[0], cnt[3]);
        else passes++;
        drive(0, 0, 1, 1);
        tick_clock();
        checks++;
        if (cnt[0] !== 4'd6 || tcv[0] !== 1'b0)
            $display("[TB] FAIL inc_and_dec: got count=%0d tc=%0b expected 6 0", cnt[0], tcv[0]);
        else passes++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : TOP) : $urandom_range(0, TOP);
            drive(v, $urandom_range(0, 9) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
            if (it == 200) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            tick_clock();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (cnt[i] !== W'(mc[i]) || tcv[i] !== mt[i][0] ||
                    zr[i] !== (mc[i] == 0) || mx[i] !== (mc[i] == TOP))
                    $display("[TB] FAIL random it %0d dut %0d: got count=%0d tc=%0b zero=%0b max=%0b expected %0d %0b %0b %0b",
                             it, i, cnt[i], tcv[i], zr[i], mx[i], mc[i], mt[i][0], mc[i] == 0, mc[i] == TOP);
                else passes++;
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        #12 reset_n = 1'b1;
        tick_clock();
        $display("[TB] starting directed scenarios");
        test_reset();
        test_load_dec();
        test_wrap();
        test_reload();
        test_prescale();
        test_priority();
        $display("[TB] starting randomized scenario");
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
